// File: rtl/mux_nto1_pipe_pkg.sv
// rtl/mux_nto1_pipe_pkg.sv - shared types and helpers for the N-to-1 pipelined selector
//
// Contents:
//   DATA_MAX_W / SEL_MAX_W : storage widths of an entry (WIDTH <= 64, SEL_W <= 8)
//   state_t                : output stage occupancy {EMPTY, ONE, FULL}
//   entry_t                : one held transfer {data, sel, sel_err}
//   sel_width()            : select width for a given channel count
package mux_nto1_pipe_pkg;

  localparam int DATA_MAX_W = 64;
  localparam int SEL_MAX_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Fields are stored at maximum width, zero-extended; the top slices them
  // back down to WIDTH / SEL_W.
  typedef struct packed {
    logic [DATA_MAX_W-1:0] data;
    logic [SEL_MAX_W-1:0]  sel;
    logic                  sel_err;
  } entry_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nto1_sel.sv
// rtl/mux_nto1_sel.sv - combinational N-to-1 channel selector with range check
//
// Ports:
//   data_i    : flat channel bus, channel k at [k*WIDTH +: WIDTH]
//   select_i  : binary channel select
//   data_o    : selected channel (channel 0 when select is out of range)
//   sel_err_o : select_i >= NUM_IN
module mux_nto1_sel #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    sel_err_o
);

  always_comb begin
    sel_err_o = (int'(select_i) >= NUM_IN);
    // Out-of-range selects fall back to channel 0.
    data_o = data_i[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (int'(select_i) == k) begin
        data_o = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// rtl/mux_nto1_pipe.sv - N-to-1 selector with registered valid/ready output stage
//
// Build option: MUX_SKID_EN adds a skid entry (FULL state) so ready_o is
// purely registered; without it ready_o = !valid_o | ready_i.
//
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : squash all held entries (drops this cycle's input)
//   data_i, select_i   : flat channel bus and binary select
//   valid_i / ready_o  : upstream handshake
//   data_o, sel_o      : selected data and the raw select that produced it
//   sel_err_o          : entry came from an out-of-range select
//   valid_o / ready_i  : downstream handshake
module mux_nto1_pipe
  import mux_nto1_pipe_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    sel_err_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  state_t state_q, state_d;
  entry_t out_q;
  entry_t new_e;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept, pop;
  logic             load_out;

  mux_nto1_sel #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .data_i   (data_i),
    .select_i (select_i),
    .data_o   (sel_data),
    .sel_err_o(sel_err)
  );

  always_comb begin
    new_e.data    = DATA_MAX_W'(sel_data);
    new_e.sel     = SEL_MAX_W'(select_i);
    new_e.sel_err = sel_err;
  end

  assign valid_o = (state_q != EMPTY);
  assign accept  = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

`ifdef MUX_SKID_EN
  entry_t skid_q;
  logic   load_skid;
  logic   skid_to_out;

  assign ready_o = (state_q != FULL);

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d  = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (accept && pop) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        state_d     = ONE;
        skid_to_out = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d     = EMPTY;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
    end
  end

  // Skid data is never cleared; its validity lives only in state_q.
  always_ff @(posedge clk_i) begin
    if (load_skid) skid_q <= new_e;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_out)         out_q <= new_e;
      else if (skid_to_out) out_q <= skid_q;
    end
  end
`else
  // Downstream stall is passed straight upstream, so ONE can only be
  // refilled on the same cycle it is popped.
  assign ready_o = !valid_o | ready_i;

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d  = ONE;
        load_out = 1'b1;
      end
      ONE: begin
        if (accept)   load_out = 1'b1;
        else if (pop) state_d  = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d  = EMPTY;
      load_out = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_out) out_q <= new_e;
    end
  end
`endif

  assign data_o    = out_q.data[WIDTH-1:0];
  assign sel_o     = out_q.sel[SEL_W-1:0];
  assign sel_err_o = out_q.sel_err;

  // Zero-extension padding above WIDTH / SEL_W is carried but never read.
  logic pad_unused;
  assign pad_unused = ^{out_q.data, out_q.sel};

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb/tb_mux_nto1_pipe.sv - directed self-checking bench for mux_nto1_pipe
module tb_mux_nto1_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    flush = 1'b0;
  logic [NUM_IN*WIDTH-1:0] data_in = '0;
  logic [SEL_W-1:0]        select = '0;
  logic                    valid_in = 1'b0;
  logic                    ready_out;
  logic [WIDTH-1:0]        data_out;
  logic [SEL_W-1:0]        sel_out;
  logic                    sel_err_out;
  logic                    valid_out;
  logic                    ready_in = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_nto1_pipe #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .data_i   (data_in),
    .select_i (select),
    .valid_i  (valid_in),
    .ready_o  (ready_out),
    .data_o   (data_out),
    .sel_o    (sel_out),
    .sel_err_o(sel_err_out),
    .valid_o  (valid_out),
    .ready_i  (ready_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".valid"},   32'(valid_out),   32'h0);
    check({tag, ".ready"},   32'(ready_out),   32'h1);
    check({tag, ".data"},    32'(data_out),    32'h0);
    check({tag, ".sel"},     32'(sel_out),     32'h0);
    check({tag, ".sel_err"}, 32'(sel_err_out), 32'h0);
  endtask

  initial begin
    // Reset
    step();
    step();
    check_reset_values("reset");

    // Basic select: channel 2 of {0x11,0x22,0x33}
    rst      = 1'b0;
    data_in  = {8'h33, 8'h22, 8'h11};
    select   = 2'd2;
    valid_in = 1'b1;
    ready_in = 1'b1;
    step();
    check("basic.data",    32'(data_out),    32'h33);
    check("basic.sel",     32'(sel_out),     32'h2);
    check("basic.valid",   32'(valid_out),   32'h1);
    check("basic.sel_err", 32'(sel_err_out), 32'h0);

    // Out-of-range select falls back to channel 0
    data_in = {8'h33, 8'h22, 8'hA5};
    select  = 2'd3;
    step();
    check("oor.data",    32'(data_out),    32'hA5);
    check("oor.sel",     32'(sel_out),     32'h3);
    check("oor.sel_err", 32'(sel_err_out), 32'h1);

    // Hold under a stall
    valid_in = 1'b0;
    ready_in = 1'b0;
    #1;
`ifdef MUX_SKID_EN
    check("stall.ready_reg", 32'(ready_out), 32'h1);
`else
    check("stall.ready_comb", 32'(ready_out), 32'h0);
`endif
    step();
    check("stall.hold_data",  32'(data_out),  32'hA5);
    check("stall.hold_valid", 32'(valid_out), 32'h1);
    ready_in = 1'b1;
    #1;
    check("release.ready", 32'(ready_out), 32'h1);

    // Streaming at one transfer per cycle
    select   = 2'd0;
    valid_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data_in = {8'h00, 8'h00, 8'(i + 8'h40)};
      step();
      check($sformatf("stream%0d.data", i), 32'(data_out),  32'(i + 8'h40));
      check($sformatf("stream%0d.valid", i), 32'(valid_out), 32'h1);
      check($sformatf("stream%0d.ready", i), 32'(ready_out), 32'h1);
    end
    valid_in = 1'b0;
    step();
    check("drain.valid", 32'(valid_out), 32'h0);

`ifdef MUX_SKID_EN
    // Back-pressure: 1,2,3 on select 0, stall from the cycle data_o=1
    valid_in = 1'b1;
    data_in  = {8'h00, 8'h00, 8'h01};
    step();
    check("bp.first", 32'(data_out), 32'h01);
    ready_in = 1'b0;
    data_in  = {8'h00, 8'h00, 8'h02};
    step();
    check("bp.full_ready", 32'(ready_out), 32'h0);
    check("bp.full_data",  32'(data_out),  32'h01);
    data_in = {8'h00, 8'h00, 8'h03};
    step();
    check("bp.still_full", 32'(ready_out), 32'h0);
    ready_in = 1'b1;
    step();
    check("bp.second", 32'(data_out), 32'h02);
    step();
    check("bp.third", 32'(data_out), 32'h03);
    valid_in = 1'b0;
    step();
    check("bp.drained", 32'(valid_out), 32'h0);

    // Flush while FULL with 0x99 offered
    valid_in = 1'b1;
    data_in  = {8'h00, 8'h00, 8'h04};
    step();
    ready_in = 1'b0;
    data_in  = {8'h00, 8'h00, 8'h05};
    step();
    check("fl.full", 32'(ready_out), 32'h0);
    flush   = 1'b1;
    data_in = {8'h00, 8'h00, 8'h99};
    step();
`else
    // Flush while ONE with 0x99 offered
    valid_in = 1'b1;
    data_in  = {8'h00, 8'h00, 8'h04};
    step();
    check("fl.loaded", 32'(data_out), 32'h04);
    ready_in = 1'b0;
    flush    = 1'b1;
    data_in  = {8'h00, 8'h00, 8'h99};
    step();
`endif
    check("fl.valid", 32'(valid_out), 32'h0);
    check("fl.ready", 32'(ready_out), 32'h1);
    check("fl.data_kept", 32'(data_out), 32'h04);
    flush    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    check("fl.no_99_valid", 32'(valid_out), 32'h0);
    check("fl.no_99_data",  32'(data_out),  32'h04);

    // Reset in ONE together with flush
    valid_in = 1'b1;
    select   = 2'd1;
    data_in  = {8'h00, 8'h77, 8'h00};
    step();
    check("rst_mid.loaded", 32'(data_out), 32'h77);
    rst   = 1'b1;
    flush = 1'b1;
    step();
    check_reset_values("rst_mid");

    rst      = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised N-to-1 datapath selector with a registered, flow-controlled output stage, the pipelined successor to the fixed 3-input operand multiplexers in the CPU datapath. It selects one of NUM_IN channels of WIDTH bits by a binary select, captures the result with a valid/ready handshake, and holds it under back-pressure. A stage-local flush supports branch/hazard squashing. It sits between the forwarding/operand-select logic and the next pipeline stage, so stall and flush are handled locally and not in each pipeline register.

## Interface
- WIDTH, 32, bits per data channel
- NUM_IN, 4, number of input channels (≥2)
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden)
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- flush_i  input  1  synchronous squash of all held entries
- data_i  input  NUM_IN*WIDTH  flat channel bus, channel k at [k*WIDTH +: WIDTH]
- select_i  input  SEL_W  binary channel select
- valid_i  input  1  upstream has a transfer
- ready_o  output  1  block can accept this cycle
- data_o  output  WIDTH  selected, registered data
- sel_o  output  SEL_W  select value that produced data_o
- sel_err_o  output  1  data_o came from an out-of-range select
- valid_o  output  1  data_o/sel_o/sel_err_o are valid
- ready_i  input  1  downstream accepts this cycle

## Operation
- Accept = valid_i & ready_o. Pop = valid_o & ready_i.
- Selection at accept: select_i < NUM_IN gives channel select_i. select_i ≥ NUM_IN gives channel 0 and sets sel_err for that entry. sel_o stores the raw select_i.
- Storage: output register OUT plus skid register SKID. Each holds {data, sel, sel_err}.
- States: EMPTY (no valid entry), ONE (OUT valid), FULL (OUT and SKID valid).
- EMPTY: accept goes to ONE, new entry into OUT.
- ONE: accept & pop stays ONE, new entry into OUT. Accept & !pop goes to FULL, new entry into SKID. Pop & !accept goes to EMPTY.
- FULL: no accept possible. Pop goes to ONE, SKID moves into OUT.
- ready_o = (state != FULL). It is registered-state-derived and never depends combinationally on ready_i.
- flush_i has priority over accept and pop. Next state is EMPTY. Data on valid_i that cycle is dropped. A pop in the same cycle still counts as consumed downstream.
- Order is strictly FIFO. No entry is duplicated or reordered.
- Data registers are not cleared when an entry is invalidated. Only valid/state are reset.

## Timing
- Reset values: valid_o=0, ready_o=1, data_o=0, sel_o=0, sel_err_o=0, state=EMPTY.
- Latency: accept in cycle n gives valid_o in cycle n+1 when the path is empty or popping.
- Throughput: 1 transfer/cycle sustained with ready_i=1. One cycle of ready_i=0 costs no upstream bubble, because SKID absorbs it.
- valid_o, once high, stays high with data_o stable until pop, flush or reset.
- Reset mid-operation (any state) gives EMPTY on the next edge, and all entries are lost. rst_i dominates flush_i.

## Configuration
- MUX_SKID_EN defined: the SKID register and FULL state are as above. ready_o is registered.
- MUX_SKID_EN undefined: SKID, FULL and the SKID data path are removed. ready_o = !valid_o | ready_i, a combinational path from ready_i. ONE & accept & !pop cannot occur. Latency, flush, reset and select rules are unchanged. Throughput is 1/cycle only while ready_i=1.

## Structure
- Shared package: the entry struct typedef {data, sel, sel_err}, the state enum {EMPTY, ONE, FULL}, and a SEL_W helper function.
- One sub-module: mux_nto1_sel. It is the combinational N-to-1 selector with range check, which outputs the selected data and the error flag. It is instantiated once at the input.

## Test plan
- Reset then basic select: NUM_IN=4, data_i channels {0x11,0x22,0x33,0x44}, select_i=2, valid_i=1, ready_i=1 → next cycle data_o=0x33, sel_o=2, valid_o=1, sel_err_o=0.
- Out-of-range select: NUM_IN=3, select_i=3, channel0=0xA5 → data_o=0xA5, sel_o=3, sel_err_o=1.
- Back-pressure (SKID on): stream 1,2,3 on select 0. Hold ready_i=0 from the cycle data_o=1. The block reaches FULL and ready_o=0 the cycle after entry 2 is accepted. After ready_i=1, output sequence is 1,2,3 with no loss or duplicate.
- Flush while FULL with valid_i=1 carrying 0x99 → next cycle valid_o=0, ready_o=1, 0x99 never appears on data_o.
- Reset mid-stream in ONE with flush_i=1 simultaneously → all outputs equal their reset values next cycle.
- SKID off build: ready_i=0 with valid_o=1 → ready_o=0 the same cycle. ready_i=1 → ready_o=1 the same cycle, at 1 transfer/cycle.
